// File: rtl/data_packet_pkg.sv
// Shared definitions for the data packet generator/checker pair: FSM states,
// register map, control bit positions, counter pattern step and LFSR constants.
package data_packet_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOP = 2'd1,
        IN_PKT   = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LEN    = 2'd1;
    localparam logic [1:0] REG_PKTCNT = 2'd2;
    localparam logic [1:0] REG_ERRCNT = 2'd3;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_STICKY    = 1;
    localparam int CTRL_LEN_CHECK = 2;
    localparam int CTRL_IN_PKT    = 3;

    localparam int          DEFAULT_STEP = 2;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    function automatic logic [31:0] next_pattern(input logic [31:0] d, input logic [15:0] step);
        next_pattern = {d[31:16] + step, d[15:0] + step};
    endfunction

endpackage

// File: rtl/data_packet_checker_sat_counter.sv
// Saturating up-counter: adds inc+inc2 (0..2) per cycle, sticks at all-ones,
// and a clear request overrides any increment in the same cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         csi_clock_clk,
    input  logic         csi_clock_reset,
    input  logic         inc,
    input  logic         inc2,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] v, input logic [1:0] n);
        logic [W:0] s;
        s = {1'b0, v} + {{(W-1){1'b0}}, n};
        sat_add = s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    logic [1:0] amount;
    assign amount = {inc & inc2, inc ^ inc2};

    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else
            cnt <= sat_add(cnt, amount);
    end

endmodule

// File: rtl/data_packet_checker.sv
// Avalon-ST sink checking the generator's counter pattern, SOP/EOP framing and
// packet length. Define CHECKER_BACKPRESSURE_EN for LFSR-throttled ready.
module data_packet_checker
    import data_packet_pkg::*;
#(
    parameter int STEP  = DEFAULT_STEP,
    parameter int CNT_W = 32
) (
    input  logic        csi_clock_clk,
    input  logic        csi_clock_reset,
    input  logic        avs_s0_write,
    input  logic        avs_s0_read,
    input  logic [1:0]  avs_s0_address,
    input  logic [3:0]  avs_s0_byteenable,
    input  logic [31:0] avs_s0_writedata,
    output logic [31:0] avs_s0_readdata,
    input  logic        asi_snk0_valid,
    output logic        asi_snk0_ready,
    input  logic [31:0] asi_snk0_data,
    input  logic [1:0]  asi_snk0_empty,
    input  logic        asi_snk0_startofpacket,
    input  logic        asi_snk0_endofpacket,
    input  logic        asi_snk0_error,
    output logic        chk_error
);

    localparam logic [15:0] STEP16 = 16'(STEP);

    state_t           state, state_nxt, eff_state;
    logic             enable_r, sticky_r, len_check_r;
    logic [15:0]      last_len_r, exp_len_r, throttle_rd;
    logic [15:0]      beat_cnt, cnt_nxt, n_beats, pkt_len;
    logic [31:0]      expected;
    logic             seeded, pkt_err, pkt_base;
    logic             beat, keep, pkt_end, frm_err, len_err, dat_mis, dat_up, pkt_bad, good, err_any;
    logic             wr_ctrl, wr_len, wr_pkt, wr_err, in_pkt;
    logic [CNT_W-1:0] pkt_cnt;
    logic [15:0]      dat_cnt, frm_cnt;
    logic             unused_inputs;

    assign unused_inputs = ^{avs_s0_read, avs_s0_writedata, avs_s0_byteenable};

    assign wr_ctrl = avs_s0_write && (avs_s0_address == REG_CTRL);
    assign wr_len  = avs_s0_write && (avs_s0_address == REG_LEN);
    assign wr_pkt  = avs_s0_write && (avs_s0_address == REG_PKTCNT);
    assign wr_err  = avs_s0_write && (avs_s0_address == REG_ERRCNT);
    assign in_pkt  = (state == IN_PKT);

`ifdef CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr, throttle_r;

    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset) begin
            lfsr       <= LFSR_SEED;
            throttle_r <= '0;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            if (wr_len && avs_s0_byteenable[2]) throttle_r[7:0]  <= avs_s0_writedata[23:16];
            if (wr_len && avs_s0_byteenable[3]) throttle_r[15:8] <= avs_s0_writedata[31:24];
        end
    end

    assign throttle_rd    = throttle_r;
    assign asi_snk0_ready = (enable_r | in_pkt) & ((throttle_r == 16'd0) | lfsr[0]);
`else
    assign throttle_rd    = 16'd0;
    // A packet already in flight keeps ready high so it can drain after ENABLE drops
    assign asi_snk0_ready = enable_r | in_pkt;
`endif

    assign beat = asi_snk0_valid & asi_snk0_ready;

    // A beat accepted while IDLE is leaving is framed as if already in WAIT_SOP
    always_comb begin
        eff_state = (state == IDLE) ? WAIT_SOP : state;
        state_nxt = state;
        cnt_nxt   = beat_cnt;
        n_beats   = beat_cnt;
        pkt_base  = pkt_err;
        keep      = 1'b0;
        frm_err   = 1'b0;
        pkt_end   = 1'b0;
        if (state == IDLE && enable_r)
            state_nxt = WAIT_SOP;
        if (beat) begin
            if (asi_snk0_startofpacket) begin
                frm_err   = (eff_state == IN_PKT);
                keep      = 1'b1;
                n_beats   = 16'd1;
                cnt_nxt   = 16'd1;
                pkt_base  = 1'b0;
                state_nxt = IN_PKT;
            end else if (eff_state == IN_PKT) begin
                keep    = 1'b1;
                n_beats = beat_cnt + 16'd1;
                cnt_nxt = beat_cnt + 16'd1;
            end else begin
                frm_err = 1'b1;
            end
            if (keep && asi_snk0_endofpacket) begin
                pkt_end   = 1'b1;
                state_nxt = WAIT_SOP;
            end
        end
        if (!enable_r && state_nxt != IN_PKT)
            state_nxt = IDLE;
    end

    assign dat_mis = keep & seeded & (asi_snk0_data != expected);
    assign dat_up  = beat & asi_snk0_error;
    assign pkt_len = (n_beats << 2) - {14'd0, asi_snk0_empty};
    assign len_err = pkt_end & len_check_r & (pkt_len != exp_len_r);
    assign pkt_bad = pkt_base | dat_mis | dat_up;
    assign good    = pkt_end & ~pkt_bad & ~len_err;
    assign err_any = dat_mis | dat_up | frm_err | len_err;

    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            pkt_err    <= 1'b0;
            seeded     <= 1'b0;
            expected   <= '0;
            last_len_r <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= cnt_nxt;
            pkt_err  <= pkt_end ? 1'b0 : pkt_bad;
            // Re-seeding from every kept beat makes a single glitch cost one extra error
            if (keep) begin
                seeded   <= 1'b1;
                expected <= next_pattern(asi_snk0_data, STEP16);
            end else if (state == IDLE) begin
                seeded <= 1'b0;
            end
            if (pkt_end)
                last_len_r <= pkt_len;
        end
    end

    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset) begin
            enable_r    <= 1'b0;
            len_check_r <= 1'b0;
            sticky_r    <= 1'b0;
            exp_len_r   <= '0;
        end else begin
            if (wr_ctrl && avs_s0_byteenable[0]) begin
                enable_r    <= avs_s0_writedata[CTRL_ENABLE];
                len_check_r <= avs_s0_writedata[CTRL_LEN_CHECK];
            end
            if (err_any)
                sticky_r <= 1'b1;
            else if (wr_ctrl && avs_s0_byteenable[0] && avs_s0_writedata[CTRL_STICKY])
                sticky_r <= 1'b0;
            if (wr_len && avs_s0_byteenable[0]) exp_len_r[7:0]  <= avs_s0_writedata[7:0];
            if (wr_len && avs_s0_byteenable[1]) exp_len_r[15:8] <= avs_s0_writedata[15:8];
        end
    end

    assign chk_error = sticky_r;

    sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .csi_clock_clk(csi_clock_clk), .csi_clock_reset(csi_clock_reset),
        .inc(good), .inc2(1'b0), .clr(wr_pkt), .cnt(pkt_cnt)
    );

    sat_counter #(.W(16)) u_dat_cnt (
        .csi_clock_clk(csi_clock_clk), .csi_clock_reset(csi_clock_reset),
        .inc(dat_mis), .inc2(dat_up), .clr(wr_err), .cnt(dat_cnt)
    );

    sat_counter #(.W(16)) u_frm_cnt (
        .csi_clock_clk(csi_clock_clk), .csi_clock_reset(csi_clock_reset),
        .inc(frm_err), .inc2(len_err), .clr(wr_err), .cnt(frm_cnt)
    );

    always_comb begin
        avs_s0_readdata = '0;
        case (avs_s0_address)
            REG_CTRL:   avs_s0_readdata = {last_len_r, 12'd0, in_pkt, len_check_r, sticky_r, enable_r};
            REG_LEN:    avs_s0_readdata = {throttle_rd, exp_len_r};
            REG_PKTCNT: avs_s0_readdata = 32'(pkt_cnt);
            default:    avs_s0_readdata = {frm_cnt, dat_cnt};
        endcase
    end

endmodule

// File: tb/tb_data_packet_checker.sv
// Self-checking bench for data_packet_checker: table of packets with a
// scoreboard queue of expected register values, plus hand-written corner cases.
`timescale 1ns/1ps
module tb_data_packet_checker;
    import data_packet_pkg::*;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        avs_write = 1'b0, avs_read = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic [3:0]  avs_be = 4'h0;
    logic [31:0] avs_wdata = '0, avs_rdata;
    logic        snk_valid = 1'b0, snk_ready;
    logic [31:0] snk_data = '0;
    logic [1:0]  snk_empty = 2'd0;
    logic        snk_sop = 1'b0, snk_eop = 1'b0, snk_err = 1'b0;
    logic        chk_error;

    always #5 clk = ~clk;

    data_packet_checker #(.STEP(2), .CNT_W(32)) dut (
        .csi_clock_clk(clk), .csi_clock_reset(rst),
        .avs_s0_write(avs_write), .avs_s0_read(avs_read), .avs_s0_address(avs_address),
        .avs_s0_byteenable(avs_be), .avs_s0_writedata(avs_wdata), .avs_s0_readdata(avs_rdata),
        .asi_snk0_valid(snk_valid), .asi_snk0_ready(snk_ready), .asi_snk0_data(snk_data),
        .asi_snk0_empty(snk_empty), .asi_snk0_startofpacket(snk_sop),
        .asi_snk0_endofpacket(snk_eop), .asi_snk0_error(snk_err), .chk_error(chk_error)
    );

    typedef struct {
        logic        reseed;
        logic [31:0] start;
        int          nb;
        logic [1:0]  empty;
        int          glitch;
        logic        lenchk;
        logic [15:0] explen;
        int          d_good, d_dat, d_frm;
        logic [15:0] len;
    } row_t;

    typedef struct {
        logic [31:0] pkt;
        logic [31:0] err;
        logic [15:0] len;
    } exp_t;

    row_t        rows[23];
    exp_t        sbq[$];
    int          n_total = 0, n_pass = 0, stalls = 0;
    int          m_good = 0, m_dat = 0, m_frm = 0;
    logic [31:0] cur_d = '0;
    logic [15:0] throttle_val = 16'd0;
    logic [31:0] rd;

    function automatic logic [31:0] gen_next(input logic [31:0] d);
        gen_next = {d[31:16] + 16'd2, d[15:0] + 16'd2};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        avs_write = 1'b1; avs_address = a; avs_wdata = d; avs_be = be;
        @(negedge clk);
        avs_write = 1'b0; avs_be = 4'h0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_read = 1'b1; avs_address = a;
        #1 d = avs_rdata;
        avs_read = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic err, input logic [1:0] emp);
        int t;
        @(negedge clk);
        snk_valid = 1'b1; snk_data = d; snk_sop = sop; snk_eop = eop; snk_err = err; snk_empty = emp;
        t = 0;
        while (!snk_ready && t < TMO) begin
            stalls++;
            @(negedge clk);
            t++;
        end
        if (t >= TMO) begin
            n_total++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, expected 1", t);
        end
        @(posedge clk);
        #1 snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; snk_err = 1'b0; snk_empty = 2'd0;
    endtask

    task automatic clear_counters();
        reg_wr(REG_PKTCNT, 32'h0, 4'hF);
        reg_wr(REG_ERRCNT, 32'h0, 4'hF);
        m_good = 0; m_dat = 0; m_frm = 0;
    endtask

    task automatic run_row(input int idx, input row_t r);
        exp_t e;
        if (r.reseed) begin
            reg_wr(REG_CTRL, 32'h0, 4'h1);
            repeat (2) @(negedge clk);
            cur_d = r.start;
        end
        reg_wr(REG_CTRL, {29'd0, r.lenchk, 1'b0, 1'b1}, 4'h1);
        reg_wr(REG_LEN, {throttle_val, r.explen}, 4'hF);
        m_good += r.d_good; m_dat += r.d_dat; m_frm += r.d_frm;
        e.pkt = m_good; e.err = {m_frm[15:0], m_dat[15:0]}; e.len = r.len;
        sbq.push_back(e);
        for (int b = 1; b <= r.nb; b++) begin
            send_beat((b == r.glitch) ? 32'hDEADBEEF : cur_d, b == 1, b == r.nb, 1'b0,
                      (b == r.nb) ? r.empty : 2'd0);
            cur_d = gen_next(cur_d);
        end
        e = sbq.pop_front();
        reg_rd(REG_PKTCNT, rd); check($sformatf("row%0d_pktcnt", idx), rd, e.pkt);
        reg_rd(REG_ERRCNT, rd); check($sformatf("row%0d_errcnt", idx), rd, e.err);
        reg_rd(REG_CTRL, rd);   check($sformatf("row%0d_len", idx), {16'd0, rd[31:16]}, {16'd0, e.len});
    endtask

    initial begin
        for (int i = 0; i < 23; i++)
            rows[i] = '{1'b0, 32'h0, 4, 2'd0, 0, 1'b1, 16'd16, 1, 0, 0, 16'd16};
        rows[0].reseed = 1'b1; rows[0].start = 32'h00010002;
        rows[12].glitch = 2; rows[12].d_good = 0; rows[12].d_dat = 2;
        rows[20] = '{1'b0, 32'h0, 3, 2'd3, 0, 1'b1, 16'd12, 0, 0, 1, 16'd9};
        rows[21] = '{1'b0, 32'h0, 3, 2'd3, 0, 1'b0, 16'd12, 1, 0, 0, 16'd9};
        rows[22] = '{1'b1, 32'hFFFE0000, 2, 2'd0, 0, 1'b0, 16'd0, 1, 0, 0, 16'd8};

        // reset state
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, snk_ready}, 32'd0);
        check("reset_chk_error", {31'd0, chk_error}, 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            reg_rd(2'(a), rd); check($sformatf("reset_reg%0d", a), rd, 32'h0);
        end
        reg_wr(REG_LEN, 32'hAAAA1234, 4'h1);
        reg_rd(REG_LEN, rd); check("reg1_byteenable", rd, 32'h00000034);

        // clean stream: 10 packets of 4 beats, length checked against 16
        for (int i = 0; i < 10; i++) run_row(i, rows[i]);
        reg_rd(REG_PKTCNT, rd); check("clean_good10", rd, 32'd10);
        reg_rd(REG_CTRL, rd);   check("clean_sticky0", {31'd0, rd[1]}, 32'd0);

        // single glitch on beat 2 of packet 3
        clear_counters();
        for (int i = 10; i < 20; i++) run_row(i, rows[i]);
        reg_rd(REG_PKTCNT, rd); check("glitch_good9", rd, 32'd9);
        reg_rd(REG_ERRCNT, rd); check("glitch_dat2", rd, 32'h00000002);
        check("glitch_chk_error", {31'd0, chk_error}, 32'd1);
        reg_wr(REG_CTRL, 32'h3, 4'h1);
        check("w1c_chk_error", {31'd0, chk_error}, 32'd0);

        // length check, then 16-bit half-word wrap
        clear_counters();
        for (int i = 20; i < 23; i++) run_row(i, rows[i]);

        // stray non-SOP beat, then a second SOP mid-packet, then a clean packet
        send_beat(32'h12345678, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int b = 1; b <= 5; b++) begin
            send_beat(cur_d, b == 1 || b == 3, b == 5, 1'b0, 2'd0);
            cur_d = gen_next(cur_d);
        end
        reg_rd(REG_CTRL, rd);   check("restart_len12", {16'd0, rd[31:16]}, 32'd12);
        for (int b = 1; b <= 2; b++) begin
            send_beat(cur_d, b == 1, b == 2, 1'b0, 2'd0);
            cur_d = gen_next(cur_d);
        end
        m_good += 2; m_frm += 2;
        reg_rd(REG_ERRCNT, rd); check("framing_errcnt", rd, {m_frm[15:0], m_dat[15:0]});
        reg_rd(REG_PKTCNT, rd); check("framing_good", rd, 32'(m_good));
        check("framing_chk_error", {31'd0, chk_error}, 32'd1);

`ifdef CHECKER_BACKPRESSURE_EN
        throttle_val = 16'd1;
        clear_counters();
        stalls = 0;
        for (int i = 0; i < 250; i++)
            run_row(100 + i, '{1'b0, 32'h0, 4, 2'd0, 0, 1'b1, 16'd16, 1, 0, 0, 16'd16});
        check("bp_ready_toggled", {31'd0, stalls != 0}, 32'd1);
        reg_rd(REG_ERRCNT, rd); check("bp_no_errors", rd, 32'h0);
`endif

        // reset in the middle of a packet
        send_beat(cur_d, 1'b1, 1'b0, 1'b0, 2'd0); cur_d = gen_next(cur_d);
        send_beat(cur_d, 1'b0, 1'b0, 1'b0, 2'd0); cur_d = gen_next(cur_d);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, snk_ready}, 32'd0);
        check("midrst_chk_error", {31'd0, chk_error}, 32'd0);
        reg_rd(REG_PKTCNT, rd); check("midrst_pktcnt", rd, 32'h0);
        reg_rd(REG_ERRCNT, rd); check("midrst_errcnt", rd, 32'h0);
        reg_rd(REG_CTRL, rd);   check("midrst_ctrl", rd, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        reg_wr(REG_CTRL, 32'h1, 4'h1);
        for (int b = 1; b <= 2; b++) begin
            send_beat(cur_d, b == 1, b == 2, 1'b0, 2'd0);
            cur_d = gen_next(cur_d);
        end
        reg_rd(REG_PKTCNT, rd); check("postrst_good1", rd, 32'd1);
        reg_rd(REG_ERRCNT, rd); check("postrst_errcnt", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
